// File: rtl/execute_pkg.sv
// Shared constants for the execute stage: opcode/function encodings, memory access sizes and
// the multiply/divide unit state type.
package execute_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned MduCycles = DataWidth;
  localparam int unsigned MduCntW   = $clog2(MduCycles);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLb    = 6'h20;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpLbu   = 6'h24;
  localparam logic [5:0] OpSb    = 6'h28;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll   = 6'h00;
  localparam logic [5:0] FnSrl   = 6'h02;
  localparam logic [5:0] FnSra   = 6'h03;
  localparam logic [5:0] FnSllv  = 6'h04;
  localparam logic [5:0] FnSrlv  = 6'h06;
  localparam logic [5:0] FnSrav  = 6'h07;
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnJalr  = 6'h09;
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnXor   = 6'h26;
  localparam logic [5:0] FnNor   = 6'h27;
  localparam logic [5:0] FnSlt   = 6'h2A;
  localparam logic [5:0] FnSltu  = 6'h2B;

  localparam logic [1:0] AccessWord = 2'b00;
  localparam logic [1:0] AccessByte = 2'b01;

  typedef enum logic [0:0] {MduIdle, MduRun} mdu_state_e;

  // MULT/MULTU/DIV/DIVU occupy function codes 0x18..0x1B.
  function automatic logic is_mdu_func(input logic [5:0] fn);
    return fn[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes; signs are applied
// combinationally on the result presented with done.
module mul_div_unit
  import execute_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic                 is_div,
  input  logic [DataWidth-1:0] op_a,
  input  logic [DataWidth-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic [DataWidth-1:0] hi,
  output logic [DataWidth-1:0] lo
);

  localparam int unsigned W = DataWidth;

  mdu_state_e           state_q, state_d;
  logic [MduCntW-1:0]   cnt_q;
  logic [W-1:0]         acc_hi_q, acc_lo_q, mag_q;
  logic                 div_q, neg_hi_q, neg_lo_q;
  logic                 a_neg, b_neg, last, ge;
  logic [W-1:0]         mag_a, mag_b, step_hi, step_lo;
  logic [W:0]           sum, rem_sh, rem_sub;
  logic [2*W-1:0]       prod_neg;

  assign a_neg = is_signed & op_a[W-1];
  assign b_neg = is_signed & op_b[W-1];
  assign mag_a = a_neg ? -op_a : op_a;
  assign mag_b = b_neg ? -op_b : op_b;
  assign last  = (state_q == MduRun) && (cnt_q == MduCntW'(MduCycles - 1));
  assign busy  = (state_q == MduRun);
  assign done  = last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MduIdle: if (start) state_d = MduRun;
      MduRun:  if (last)  state_d = MduIdle;
      default: state_d = MduIdle;
    endcase
  end

  always_comb begin
    sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_q} : '0);
    rem_sh  = {acc_hi_q, acc_lo_q[W-1]};
    rem_sub = rem_sh - {1'b0, mag_q};
    ge      = rem_sh >= {1'b0, mag_q};
    if (div_q) begin
      step_hi = ge ? rem_sub[W-1:0] : rem_sh[W-1:0];
      step_lo = {acc_lo_q[W-2:0], ge};
    end else begin
      {step_hi, step_lo} = {sum, acc_lo_q[W-1:1]};
    end
  end

  assign prod_neg = -{step_hi, step_lo};
  assign hi = div_q ? (neg_hi_q ? -step_hi : step_hi) : (neg_lo_q ? prod_neg[2*W-1:W] : step_hi);
  assign lo = div_q ? (neg_lo_q ? -step_lo : step_lo) : (neg_lo_q ? prod_neg[W-1:0] : step_lo);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= MduIdle;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mag_q    <= '0;
      div_q    <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
    end else if (start && state_q == MduIdle) begin
      cnt_q    <= '0;
      div_q    <= is_div;
      acc_hi_q <= '0;
      if (is_div) begin
        acc_lo_q <= mag_a;
        mag_q    <= mag_b;
        // Divide by zero: quotient stays all-ones, remainder restores to the dividend.
        neg_lo_q <= (op_b != '0) & (a_neg ^ b_neg);
        neg_hi_q <= a_neg;
      end else begin
        acc_lo_q <= mag_b;
        mag_q    <= mag_a;
        neg_lo_q <= a_neg ^ b_neg;
        neg_hi_q <= 1'b0;
      end
    end else if (state_q == MduRun) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
      cnt_q    <= cnt_q + MduCntW'(1);
    end
  end

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU, branch resolution and memory control, registered toward the
// memory stage, plus HI/LO fed by the iterative multiply/divide unit.
module execute
  import execute_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable_execute,
  input  logic [5:0]  opcode_in,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic [4:0]  sa_in,
  input  logic [5:0]  func_in,
  input  logic [25:0] imm_in,
  input  logic [31:0] pc_in,
  input  logic        stall,
  output logic        busy,
  output logic        valid_out,
  output logic [31:0] alu_result,
  output logic [31:0] store_data,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  access_size,
  output logic        load_unsigned,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        overflow
);

  logic [31:0] hi_q, lo_q, mdu_hi, mdu_lo;
  logic        mdu_busy, mdu_done, mdu_start, accept;
  logic [31:0] imm_sext, imm_zext, pc_plus4, sum_rr, diff_rr, sum_ri;
  logic        add_ovf, sub_ovf, addi_ovf;
  logic [31:0] res_d, tgt_d;
  logic [4:0]  dest_d;
  logic [1:0]  size_d;
  logic        wr_d, mrd_d, mwr_d, lu_d, br_d, ovf_d;

  assign busy      = stall | mdu_busy;
  assign accept    = enable_execute & ~busy;
  assign mdu_start = accept & (opcode_in == OpRtype) & is_mdu_func(func_in);

  mul_div_unit u_mdu (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (mdu_start),
    .is_signed (~func_in[0]),
    .is_div    (func_in[1]),
    .op_a      (rs_data),
    .op_b      (rt_data),
    .busy      (mdu_busy),
    .done      (mdu_done),
    .hi        (mdu_hi),
    .lo        (mdu_lo)
  );

  assign imm_sext = {{16{imm_in[15]}}, imm_in[15:0]};
  assign imm_zext = {16'b0, imm_in[15:0]};
  assign pc_plus4 = pc_in + 32'd4;
  assign sum_rr   = rs_data + rt_data;
  assign diff_rr  = rs_data - rt_data;
  assign sum_ri   = rs_data + imm_sext;
  assign add_ovf  = (rs_data[31] == rt_data[31]) & (sum_rr[31] != rs_data[31]);
  assign sub_ovf  = (rs_data[31] != rt_data[31]) & (diff_rr[31] != rs_data[31]);
  assign addi_ovf = (rs_data[31] == imm_sext[31]) & (sum_ri[31] != rs_data[31]);

  always_comb begin
    res_d  = '0;
    tgt_d  = '0;
    dest_d = '0;
    size_d = AccessWord;
    wr_d   = 1'b0;
    mrd_d  = 1'b0;
    mwr_d  = 1'b0;
    lu_d   = 1'b0;
    br_d   = 1'b0;
    ovf_d  = 1'b0;
    case (opcode_in)
      OpRtype: begin
        dest_d = rd_in;
        case (func_in)
          FnSll:   begin res_d = rt_data << sa_in;                    wr_d = 1'b1; end
          FnSrl:   begin res_d = rt_data >> sa_in;                    wr_d = 1'b1; end
          FnSra:   begin res_d = $signed(rt_data) >>> sa_in;          wr_d = 1'b1; end
          FnSllv:  begin res_d = rt_data << rs_data[4:0];             wr_d = 1'b1; end
          FnSrlv:  begin res_d = rt_data >> rs_data[4:0];             wr_d = 1'b1; end
          FnSrav:  begin res_d = $signed(rt_data) >>> rs_data[4:0];   wr_d = 1'b1; end
          FnJr:    begin br_d = 1'b1; tgt_d = rs_data; end
          FnJalr:  begin br_d = 1'b1; tgt_d = rs_data; res_d = pc_in + 32'd8; wr_d = 1'b1; end
          FnMfhi:  begin res_d = hi_q; wr_d = 1'b1; end
          FnMflo:  begin res_d = lo_q; wr_d = 1'b1; end
          FnAdd:   begin res_d = sum_rr;  ovf_d = add_ovf; wr_d = ~add_ovf; end
          FnAddu:  begin res_d = sum_rr;  wr_d = 1'b1; end
          FnSub:   begin res_d = diff_rr; ovf_d = sub_ovf; wr_d = ~sub_ovf; end
          FnSubu:  begin res_d = diff_rr; wr_d = 1'b1; end
          FnAnd:   begin res_d = rs_data & rt_data;    wr_d = 1'b1; end
          FnOr:    begin res_d = rs_data | rt_data;    wr_d = 1'b1; end
          FnXor:   begin res_d = rs_data ^ rt_data;    wr_d = 1'b1; end
          FnNor:   begin res_d = ~(rs_data | rt_data); wr_d = 1'b1; end
          FnSlt:   begin res_d = {31'b0, $signed(rs_data) < $signed(rt_data)}; wr_d = 1'b1; end
          FnSltu:  begin res_d = {31'b0, rs_data < rt_data};                   wr_d = 1'b1; end
          default: ;
        endcase
      end
      OpJ:     begin br_d = 1'b1; tgt_d = {pc_plus4[31:28], imm_in, 2'b00}; end
      OpJal:   begin
        br_d   = 1'b1;
        tgt_d  = {pc_plus4[31:28], imm_in, 2'b00};
        res_d  = pc_in + 32'd8;
        dest_d = 5'd31;
        wr_d   = 1'b1;
      end
      OpBeq:   begin tgt_d = pc_plus4 + {imm_sext[29:0], 2'b00}; br_d = (rs_data == rt_data); end
      OpBne:   begin tgt_d = pc_plus4 + {imm_sext[29:0], 2'b00}; br_d = (rs_data != rt_data); end
      OpAddi:  begin res_d = sum_ri; dest_d = rt_in; ovf_d = addi_ovf; wr_d = ~addi_ovf; end
      OpAddiu: begin res_d = sum_ri; dest_d = rt_in; wr_d = 1'b1; end
      OpSlti:  begin
        res_d  = {31'b0, $signed(rs_data) < $signed(imm_sext)};
        dest_d = rt_in;
        wr_d   = 1'b1;
      end
      OpSltiu: begin res_d = {31'b0, rs_data < imm_sext}; dest_d = rt_in; wr_d = 1'b1; end
      OpAndi:  begin res_d = rs_data & imm_zext; dest_d = rt_in; wr_d = 1'b1; end
      OpOri:   begin res_d = rs_data | imm_zext; dest_d = rt_in; wr_d = 1'b1; end
      OpXori:  begin res_d = rs_data ^ imm_zext; dest_d = rt_in; wr_d = 1'b1; end
      OpLui:   begin res_d = {imm_in[15:0], 16'b0}; dest_d = rt_in; wr_d = 1'b1; end
      OpLw:    begin res_d = sum_ri; dest_d = rt_in; wr_d = 1'b1; mrd_d = 1'b1; end
      OpLb, OpLbu: begin
        res_d  = sum_ri;
        dest_d = rt_in;
        wr_d   = 1'b1;
        mrd_d  = 1'b1;
        size_d = AccessByte;
        lu_d   = (opcode_in == OpLbu);
      end
      OpSw:    begin res_d = sum_ri; mwr_d = 1'b1; end
      OpSb:    begin res_d = sum_ri; mwr_d = 1'b1; size_d = AccessByte; end
      default: ;
    endcase
    if (dest_d == 5'd0) wr_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mdu_done) begin
      hi_q <= mdu_hi;
      lo_q <= mdu_lo;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_out     <= 1'b0;
      alu_result    <= '0;
      store_data    <= '0;
      dest_reg      <= '0;
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      access_size   <= AccessWord;
      load_unsigned <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      overflow      <= 1'b0;
    end else if (accept) begin
      valid_out     <= 1'b1;
      alu_result    <= res_d;
      store_data    <= rt_data;
      dest_reg      <= dest_d;
      reg_write     <= wr_d;
      mem_read      <= mrd_d;
      mem_write     <= mwr_d;
      access_size   <= size_d;
      load_unsigned <= lu_d;
      branch_taken  <= br_d;
      branch_target <= tgt_d;
      overflow      <= ovf_d;
    end else if (!stall) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: ALU, branches, loads/stores, stall, mul/div timing
// and reset during a multiply.
module tb_execute;
  import execute_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable_execute = 1'b0;
  logic [5:0]  opcode_in = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [4:0]  rt_in = '0;
  logic [4:0]  rd_in = '0;
  logic [4:0]  sa_in = '0;
  logic [5:0]  func_in = '0;
  logic [25:0] imm_in = '0;
  logic [31:0] pc_in = '0;
  logic        stall = 1'b0;
  logic        busy, valid_out, reg_write, mem_read, mem_write, load_unsigned;
  logic        branch_taken, overflow;
  logic [31:0] alu_result, store_data, branch_target;
  logic [4:0]  dest_reg;
  logic [1:0]  access_size;

  int tests = 0;
  int fails = 0;
  int n;

  execute dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable_execute (enable_execute),
    .opcode_in      (opcode_in),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .rt_in          (rt_in),
    .rd_in          (rd_in),
    .sa_in          (sa_in),
    .func_in        (func_in),
    .imm_in         (imm_in),
    .pc_in          (pc_in),
    .stall          (stall),
    .busy           (busy),
    .valid_out      (valid_out),
    .alu_result     (alu_result),
    .store_data     (store_data),
    .dest_reg       (dest_reg),
    .reg_write      (reg_write),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .access_size    (access_size),
    .load_unsigned  (load_unsigned),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] rtf, input logic [4:0] rd,
                       input logic [4:0] sa, input logic [25:0] imm, input logic [31:0] pc);
    enable_execute = 1'b1;
    opcode_in = op;
    func_in   = fn;
    rs_data   = rs;
    rt_data   = rt;
    rt_in     = rtf;
    rd_in     = rd;
    sa_in     = sa;
    imm_in    = imm;
    pc_in     = pc;
  endtask

  // Issue a mul/div op, wait out the unit, then read LO and HI back through MFLO/MFHI.
  task automatic run_mdu(input string tag, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int cycles;
    drive(OpRtype, fn, a, b, '0, '0, '0, '0, '0);
    tick();
    chk({tag, "_valid"}, 32'(valid_out), 32'd1);
    chk({tag, "_regw"}, 32'(reg_write), 32'd0);
    drive(OpRtype, FnMflo, '0, '0, '0, 5'd8, '0, '0, '0);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(cycles), 32'd32);
    tick();
    chk({tag, "_lo"}, alu_result, exp_lo);
    drive(OpRtype, FnMfhi, '0, '0, '0, 5'd9, '0, '0, '0);
    tick();
    chk({tag, "_hi"}, alu_result, exp_hi);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_alu", alu_result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_regw", 32'(reg_write), 32'd0);
    chk("rst_target", branch_target, 32'd0);
    tick();
    reset_n = 1'b1;

    drive(OpRtype, FnAddu, 32'hFFFFFFFF, 32'd1, '0, 5'd5, '0, '0, '0);
    tick();
    chk("addu_alu", alu_result, 32'd0);
    chk("addu_regw", 32'(reg_write), 32'd1);
    chk("addu_dest", 32'(dest_reg), 32'd5);
    chk("addu_ovf", 32'(overflow), 32'd0);
    chk("addu_valid", 32'(valid_out), 32'd1);

    drive(OpRtype, FnAdd, 32'h7FFFFFFF, 32'd1, '0, 5'd5, '0, '0, '0);
    tick();
    chk("add_ovf", 32'(overflow), 32'd1);
    chk("add_regw", 32'(reg_write), 32'd0);
    chk("add_alu", alu_result, 32'h80000000);

    enable_execute = 1'b0;
    tick();
    chk("idle_valid", 32'(valid_out), 32'd0);
    chk("idle_hold", alu_result, 32'h80000000);

    drive(OpBeq, '0, 32'd7, 32'd7, '0, '0, '0, 26'h000FFFC, 32'h80020010);
    tick();
    chk("beq_taken", 32'(branch_taken), 32'd1);
    chk("beq_target", branch_target, 32'h80020004);
    chk("beq_regw", 32'(reg_write), 32'd0);
    opcode_in = OpBne;
    tick();
    chk("bne_taken", 32'(branch_taken), 32'd0);
    chk("bne_target", branch_target, 32'h80020004);

    drive(OpRtype, FnSlt, 32'hFFFFFFFF, 32'd1, '0, 5'd6, '0, '0, '0);
    tick();
    chk("slt", alu_result, 32'd1);
    func_in = FnSltu;
    tick();
    chk("sltu", alu_result, 32'd0);
    drive(OpRtype, FnSra, '0, 32'h80000000, '0, 5'd7, 5'd4, '0, '0);
    tick();
    chk("sra", alu_result, 32'hF8000000);
    drive(OpRtype, FnSrlv, 32'd4, 32'h80000000, '0, 5'd7, 5'd0, '0, '0);
    tick();
    chk("srlv", alu_result, 32'h08000000);
    drive(OpLui, '0, '0, '0, 5'd3, '0, '0, 26'h0001234, '0);
    tick();
    chk("lui", alu_result, 32'h12340000);
    chk("lui_dest", 32'(dest_reg), 32'd3);
    drive(OpOri, '0, 32'hFFFF0000, '0, 5'd3, '0, '0, 26'h0008001, '0);
    tick();
    chk("ori_zext", alu_result, 32'hFFFF8001);
    drive(OpAddi, '0, 32'd0, '0, 5'd3, '0, '0, 26'h000FFFF, '0);
    tick();
    chk("addi_sext", alu_result, 32'hFFFFFFFF);
    drive(OpAddiu, '0, 32'd1, '0, 5'd0, '0, '0, 26'h0000001, '0);
    tick();
    chk("r0_regw", 32'(reg_write), 32'd0);
    drive(OpJal, '0, '0, '0, '0, '0, '0, 26'h0000040, 32'h00400000);
    tick();
    chk("jal_target", branch_target, 32'h00000100);
    chk("jal_link", alu_result, 32'h00400008);
    chk("jal_dest", 32'(dest_reg), 32'd31);
    chk("jal_taken", 32'(branch_taken), 32'd1);
    drive(OpLbu, '0, 32'h00000100, '0, 5'd4, '0, '0, 26'h000FFFF, '0);
    tick();
    chk("lbu_addr", alu_result, 32'h000000FF);
    chk("lbu_size", 32'(access_size), 32'd1);
    chk("lbu_unsigned", 32'(load_unsigned), 32'd1);
    chk("lbu_read", 32'(mem_read), 32'd1);
    drive(6'h3F, '0, 32'd1, 32'd1, 5'd4, 5'd4, '0, '0, '0);
    tick();
    chk("undef_valid", 32'(valid_out), 32'd1);
    chk("undef_regw", 32'(reg_write), 32'd0);
    chk("undef_mem", 32'({mem_read, mem_write}), 32'd0);
    chk("undef_branch", 32'(branch_taken), 32'd0);

    run_mdu("mult", FnMult, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFF);
    run_mdu("divu", FnDivu, 32'd100, 32'd7, 32'd14, 32'd2);
    run_mdu("divu0", FnDivu, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9);
    run_mdu("div", FnDiv, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);

    drive(OpSw, '0, 32'h80020000, 32'hDEADBEEF, 5'd2, '0, '0, 26'h0000008, '0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_valid", 32'(valid_out), 32'd1);
      chk("stall_alu", alu_result, 32'hFFFFFFFF);
      chk("stall_memw", 32'(mem_write), 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("sw_addr", alu_result, 32'h80020008);
    chk("sw_memw", 32'(mem_write), 32'd1);
    chk("sw_data", store_data, 32'hDEADBEEF);
    chk("sw_regw", 32'(reg_write), 32'd0);

    drive(OpRtype, FnMult, 32'd3, 32'd5, '0, '0, '0, '0, '0);
    tick();
    enable_execute = 1'b0;
    repeat (10) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_valid", 32'(valid_out), 32'd0);
    chk("rstmid_alu", alu_result, 32'd0);
    #2 reset_n = 1'b1;
    drive(OpAddiu, '0, 32'd5, '0, 5'd4, '0, '0, 26'h0000003, '0);
    tick();
    chk("post_addiu", alu_result, 32'd8);
    chk("post_valid", 32'(valid_out), 32'd1);
    chk("post_dest", 32'(dest_reg), 32'd4);
    drive(OpRtype, FnMflo, '0, '0, '0, 5'd2, '0, '0, '0);
    tick();
    chk("post_lo", alu_result, 32'd0);
    func_in = FnMfhi;
    tick();
    chk("post_hi", alu_result, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- Pipeline stage directly downstream of decode in the 5-stage MIPS core.
- Registers the decoded fields and the register-file read data on accept, then performs the ALU operation, branch/jump resolution and memory-control generation.
- Drives registered results to the memory stage.
- Contains an iterative 32-cycle multiply/divide unit with HI/LO registers; it back-pressures decode while the unit is running.

Parameters:
data_width, 32, datapath width
mdu_cycles, 32, iterations per MULT/MULTU/DIV/DIVU (equals data_width)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
enable_execute  input  1  decode presents a valid instruction
opcode_in  input  6  decoded opcode
rs_data  input  32  register-file value of rs
rt_data  input  32  register-file value of rt
rt_in  input  5  rt field
rd_in  input  5  rd field
sa_in  input  5  shift amount
func_in  input  6  R-type function
imm_in  input  26  immediate/jump field (low 16 bits = imm16)
pc_in  input  32  instruction PC
stall  input  1  memory stage cannot accept
busy  output  1  execute cannot accept this cycle
valid_out  output  1  output bundle valid
alu_result  output  32  ALU result / effective address / link value
store_data  output  32  rt_data forwarded for stores
dest_reg  output  5  writeback register
reg_write  output  1  writeback enable
mem_read  output  1  load
mem_write  output  1  store
access_size  output  2  00 = word, 01 = byte (LB/LBU/SB)
load_unsigned  output  1  LBU
branch_taken  output  1  redirect fetch
branch_target  output  32  redirect address
overflow  output  1  signed overflow on ADD/ADDI/SUB

Behaviour:
- Reset (async, reset_n=0): every output is 0, HI=LO=0, mul/div unit goes to IDLE. Reset asserted mid-operation aborts the unit and leaves HI/LO at 0.
- busy = stall OR mdu_running. Accept occurs on a rising edge with enable_execute=1 and busy=0.
- Latency is 1 cycle. All outputs are updated on the accept edge.
- Edge with no accept and stall=0: valid_out<=0, other outputs hold.
- stall=1: all outputs hold.
- Arithmetic:
  - ADDU/SUBU/ADDIU wrap mod 2^32.
  - ADD/SUB/ADDI set overflow=1 and reg_write=0 on signed overflow.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
- Immediates: ANDI/ORI/XORI zero-extend imm16. All other immediates sign-extend. LUI gives {imm16,16'b0}.
- Shifts: SLL/SRL/SRA use sa_in; SLLV/SRLV/SRAV use rs_data[4:0].
- dest_reg: R-type writes rd_in; I-type writes rt_in; JAL writes 31.
- Writes to register 0 force reg_write=0.
- Loads/stores (LW, LB, LBU, SW, SB): alu_result = rs_data + sext(imm16).
- Branches:
  - BEQ/BNE: branch_target = pc_in+4+(sext(imm16)<<2); branch_taken per compare.
  - J/JAL: branch_target = {pc_in_plus4[31:28], imm_in, 2'b00}; always taken.
  - JR/JALR: branch_target = rs_data; always taken.
  - JAL/JALR link value: alu_result = pc_in+8.
- MFHI/MFLO: alu_result = HI/LO, written to rd.
- MULT/MULTU/DIV/DIVU:
  - Accepted at edge E0 with valid_out=1 and reg_write=0.
  - Unit states: IDLE -> RUN, counter 0..mdu_cycles-1 -> IDLE.
  - busy=1 from E0 through E32. HI/LO written at E32. Next accept is possible at E33.
  - Signed ops iterate on magnitudes and sign-correct in the final step. Product goes to HI:LO.
  - Division: LO=quotient, HI=remainder; remainder takes the sign of the dividend.
  - Divide by zero: LO=32'hFFFFFFFF, HI=rs_data. No flag is raised.
- Undefined opcode/func: valid_out=1, all write/mem/branch controls 0.

Decomposition:
- Package execute_pkg: opcode and func localparams, access_size encodings, mdu state enum.
- Sub-module mul_div_unit: operands, start, signed and op-select in; busy, done, hi and lo out; owns the counter and FSM.
- HI/LO registers live in execute.

Test Plan:
- ADDU rs=32'hFFFFFFFF, rt=1, rd=5 -> next edge: alu_result=0, reg_write=1, dest_reg=5, overflow=0. ADD with rs=32'h7FFFFFFF, rt=1 -> overflow=1, reg_write=0.
- BEQ pc=32'h80020010, rs=rt=7, imm16=16'hFFFC -> branch_taken=1, branch_target=32'h80020004. BNE with the same operands -> branch_taken=0.
- MULT rs=-3, rt=5, then MFLO/MFHI held on enable_execute -> busy high 32 cycles; MFLO accepted at E33 giving alu_result=32'hFFFFFFF1; MFHI returns 32'hFFFFFFFF.
- DIVU 100/7 -> LO=14, HI=2. DIVU rs=9, rt=0 -> LO=32'hFFFFFFFF, HI=9. DIV -7/2 -> LO=-3, HI=-1.
- SW rs=32'h80020000, imm16=8 during stall=1 for 3 cycles -> outputs frozen; after release alu_result=32'h80020008, mem_write=1, store_data=rt_data.
- Reset asserted at iteration 10 of a MULT -> busy=0 and HI=LO=0 immediately; ADDIU accepted on the first edge after release.
